// File: rtl/game_pkg.sv
// game_pkg: constants shared by the game objects and the frame scheduler.
//   - FSM state encoding (3-bit, legacy-compatible constants)
//   - screen and sprite geometry
//   - colour constants
package game_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] E_SEL = 3'd1;
  localparam logic [2:0] E_PIX = 3'd2;
  localparam logic [2:0] D_SEL = 3'd3;
  localparam logic [2:0] D_PIX = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPR_W    = 4;
  localparam int SPR_H    = 4;

  localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/sprite_frame_scheduler_if.sv
// sprite_frame_scheduler_if: pixel-write bus into the VGA adapter.
//   x, y     pixel address
//   colour   pixel colour
//   writeEn  write strobe
// Handshake: writeEn is a valid-only strobe. The adapter always accepts,
// so there is no ready; a pixel is written on every clock edge where
// writeEn=1, with x/y/colour stable for that same cycle.
// Modports: master = scheduler (drives), slave = VGA adapter (samples).
interface sprite_frame_scheduler_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;

  modport master (output x, y, colour, writeEn);
  modport slave  (input  x, y, colour, writeEn);
endinterface

// File: rtl/sprite_pixel_counter.sv
// sprite_pixel_counter: row-major dx/dy walker over a W x H sprite.
//   clk, resetn  clock, synchronous active-low reset
//   clr          return to (0,0); wins over en
//   en           advance one pixel (dx inner, dy outer); wraps after last
//   dx, dy       current pixel offset
//   last         high while at (W-1, H-1)
module sprite_pixel_counter #(
  parameter  int W   = 4,
  parameter  int H   = 4,
  localparam int DXW = (W > 1) ? $clog2(W) : 1,
  localparam int DYW = (H > 1) ? $clog2(H) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           en,
  output logic [DXW-1:0] dx,
  output logic [DYW-1:0] dy,
  output logic           last
);

  logic dx_end;
  logic dy_end;

  assign dx_end = (dx == DXW'(W - 1));
  assign dy_end = (dy == DYW'(H - 1));
  assign last   = dx_end && dy_end;

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx_end) begin
        dx <= '0;
        dy <= dy_end ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler: owns the VGA pixel-write port for one frame.
// On frame_tick it snapshots all sprite slots, erases last frame's
// footprints in black, then draws the new ones, one pixel per cycle.
//   clk, resetn        clock, synchronous active-low reset
//   frame_tick         one-cycle frame start pulse
//   active/spr_x/y/c   per-slot enable, top-left position, colour (packed)
//   pix                pixel-write bus (master side)
//   busy               state != IDLE
//   frame_done         high during the single DONE cycle
//   overrun            sticky: frame_tick seen while not IDLE
//   state_dbg          current FSM state
module sprite_frame_scheduler #(
  parameter int N_SPR = 6,
  parameter int SPR_W = game_pkg::SPR_W,
  parameter int SPR_H = game_pkg::SPR_H,
  parameter int X_MAX = game_pkg::SCREEN_W,
  parameter int Y_MAX = game_pkg::SCREEN_H
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic [N_SPR-1:0]     active,
  input  logic [8*N_SPR-1:0]   spr_x,
  input  logic [7*N_SPR-1:0]   spr_y,
  input  logic [3*N_SPR-1:0]   spr_c,
  sprite_frame_scheduler_if.master pix,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [2:0]           state_dbg
);
  import game_pkg::*;

  localparam int IW  = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SPR - 1);

  logic [2:0]       state;
  logic [IW-1:0]    idx;
  logic [N_SPR-1:0] prev_act, cur_act;
  logic [7:0]       prev_x [N_SPR];
  logic [6:0]       prev_y [N_SPR];
  logic [7:0]       cur_x  [N_SPR];
  logic [6:0]       cur_y  [N_SPR];
  logic [2:0]       cur_c  [N_SPR];

  logic           start;
  logic           pix_state;
  logic           erase;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic           pix_last;

  assign start     = (state == IDLE) && frame_tick;
  assign erase     = (state == E_PIX);
  assign pix_state = (state == E_PIX) || (state == D_PIX);

  sprite_pixel_counter #(.W(SPR_W), .H(SPR_H)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .en     (pix_state),
    .dx     (dx),
    .dy     (dy),
    .last   (pix_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      idx      <= '0;
      overrun  <= 1'b0;
      prev_act <= '0;
      cur_act  <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        prev_x[i] <= '0;
        prev_y[i] <= '0;
        cur_x[i]  <= '0;
        cur_y[i]  <= '0;
        cur_c[i]  <= '0;
      end
    end else begin
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            // Last frame's draw becomes this frame's erase list.
            prev_act <= cur_act;
            cur_act  <= active;
            for (int i = 0; i < N_SPR; i++) begin
              prev_x[i] <= cur_x[i];
              prev_y[i] <= cur_y[i];
              cur_x[i]  <= spr_x[8*i +: 8];
              cur_y[i]  <= spr_y[7*i +: 7];
              cur_c[i]  <= spr_c[3*i +: 3];
            end
            idx   <= '0;
            state <= E_SEL;
          end
        end
        E_SEL: begin
          if (prev_act[idx]) begin
            state <= E_PIX;
          end else if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= D_SEL;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        E_PIX: begin
          if (pix_last) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= D_SEL;
            end else begin
              idx   <= idx + 1'b1;
              state <= E_SEL;
            end
          end
        end
        D_SEL: begin
          if (cur_act[idx]) begin
            state <= D_PIX;
          end else if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        D_PIX: begin
          if (pix_last) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= D_SEL;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Widened adders so sprites near the right/bottom edge clip instead of
  // wrapping onto the opposite side of the screen.
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] px;
  logic [7:0] py;
  logic       in_range;

  assign base_x   = erase ? prev_x[idx] : cur_x[idx];
  assign base_y   = erase ? prev_y[idx] : cur_y[idx];
  assign px       = {1'b0, base_x} + 9'(dx);
  assign py       = {1'b0, base_y} + 8'(dy);
  assign in_range = (px < 9'(X_MAX)) && (py < 8'(Y_MAX));

  logic [7:0] x_o;
  logic [6:0] y_o;
  logic [2:0] c_o;
  logic       we_o;

  always_comb begin
    x_o  = '0;
    y_o  = '0;
    c_o  = '0;
    we_o = 1'b0;
    if (pix_state) begin
      x_o  = px[7:0];
      y_o  = py[6:0];
      c_o  = erase ? BLACK : cur_c[idx];
      we_o = in_range;
    end
  end

  assign pix.x       = x_o;
  assign pix.y       = y_o;
  assign pix.colour  = c_o;
  assign pix.writeEn = we_o;

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb_sprite_frame_scheduler: table-driven frames, hand-written overrun and
// mid-frame reset sequences, and randomized frames, all compared cycle by
// cycle against a behavioural model of the frame's pixel sequence.
module tb_sprite_frame_scheduler;
  import game_pkg::*;

  localparam int N = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  logic          frame_tick = 1'b0;
  logic [N-1:0]  active = '0;
  logic [8*N-1:0] spr_x = '0;
  logic [7*N-1:0] spr_y = '0;
  logic [3*N-1:0] spr_c = '0;
  logic busy, frame_done, overrun;
  logic [2:0] state_dbg;

  sprite_frame_scheduler_if pif ();

  sprite_frame_scheduler #(.N_SPR(N)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .active     (active),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_c      (spr_c),
    .pix        (pif),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // record: {busy, frame_done, writeEn, x[7:0], y[6:0], colour[2:0]}
  logic [20:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [20:0] obs();
    return {busy, frame_done, pif.writeEn, pif.x, pif.y, pif.colour};
  endfunction

  // ---------------- reference model ----------------
  logic [N-1:0] m_prev_act = '0, m_cur_act = '0;
  int m_prev_x[N], m_prev_y[N], m_cur_x[N], m_cur_y[N], m_cur_c[N];

  function automatic logic [20:0] rec(input bit b, input bit d, input bit w,
                                      input int xx, input int yy, input int cc);
    logic [7:0] x8;
    logic [6:0] y7;
    logic [2:0] c3;
    x8 = 8'(xx);
    y7 = 7'(yy);
    c3 = 3'(cc);
    return {b, d, w, x8, y7, c3};
  endfunction

  task automatic model_reset();
    m_prev_act = '0;
    m_cur_act  = '0;
    for (int i = 0; i < N; i++) begin
      m_prev_x[i] = 0; m_prev_y[i] = 0;
      m_cur_x[i] = 0; m_cur_y[i] = 0; m_cur_c[i] = 0;
    end
    exp_q.delete();
  endtask

  // Builds the whole frame: for each phase, each slot gets one select cycle
  // followed (if it takes part) by 16 pixels in row-major order; then DONE.
  task automatic model_tick(input logic [N-1:0] act, input logic [8*N-1:0] xs,
                            input logic [7*N-1:0] ys, input logic [3*N-1:0] cs);
    int bx, by, px, py;
    bit part;
    m_prev_act = m_cur_act;
    m_cur_act  = act;
    for (int i = 0; i < N; i++) begin
      m_prev_x[i] = m_cur_x[i];
      m_prev_y[i] = m_cur_y[i];
      m_cur_x[i]  = int'(xs[8*i +: 8]);
      m_cur_y[i]  = int'(ys[7*i +: 7]);
      m_cur_c[i]  = int'(cs[3*i +: 3]);
    end
    exp_q.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(rec(1, 0, 0, 0, 0, 0));
        part = (ph == 0) ? m_prev_act[i] : m_cur_act[i];
        bx   = (ph == 0) ? m_prev_x[i] : m_cur_x[i];
        by   = (ph == 0) ? m_prev_y[i] : m_cur_y[i];
        if (part) begin
          for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
              px = bx + dx;
              py = by + dy;
              exp_q.push_back(rec(1, 0, (px < 160) && (py < 120), px, py,
                                  (ph == 0) ? 0 : m_cur_c[i]));
            end
          end
        end
      end
    end
    exp_q.push_back(rec(1, 1, 0, 0, 0, 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    active = N'($urandom);
    spr_x  = (8*N)'({$urandom(), $urandom()});
    spr_y  = (7*N)'({$urandom(), $urandom()});
    spr_c  = (3*N)'($urandom);
  endtask

  task automatic start_frame(input logic [N-1:0] act, input logic [8*N-1:0] xs,
                             input logic [7*N-1:0] ys, input logic [3*N-1:0] cs);
    @(negedge clk);
    active = act; spr_x = xs; spr_y = ys; spr_c = cs;
    frame_tick = 1'b1;
    model_tick(act, xs, ys, cs);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    scramble_inputs();
  endtask

  // Runs one frame from the tick; n=0 is the cycle after the tick edge.
  // ovr_at >= 0 pulses frame_tick once at that cycle.
  task automatic run_frame(input string tag, input logic [N-1:0] act,
                           input logic [8*N-1:0] xs, input logic [7*N-1:0] ys,
                           input logic [3*N-1:0] cs, input int ovr_at,
                           output int writes, output int cycles,
                           output int first_we, output int done_at);
    int n, bad, first_bad;
    logic [20:0] o, e, o_bad, e_bad;
    start_frame(act, xs, ys, cs);
    n = 0; bad = 0; first_bad = -1; writes = 0; first_we = -1; done_at = -1;
    o_bad = '0; e_bad = '0;
    while (busy && n < 1000) begin
      o = obs();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      if (o !== e) begin
        bad++;
        if (first_bad < 0) begin first_bad = n; o_bad = o; e_bad = e; end
      end
      if (pif.writeEn === 1'b1) begin
        writes++;
        if (first_we < 0) first_we = n;
      end
      if (frame_done === 1'b1) done_at = n;
      if (n == ovr_at) frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      n++;
    end
    cycles = n;
    check({tag, "_timeout"}, 32'(n >= 1000), 0);
    checks++;
    if (bad != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_seq cycle %0d actual=%h required=%h (bad cycles %0d, missing %0d)",
               tag, first_bad, o_bad, e_bad, bad, exp_q.size());
    end
    check({tag, "_idle_out"}, 32'(obs()), 0);
    check({tag, "_done_last"}, done_at, cycles - 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]   act;
    logic [8*N-1:0] xs;
    logic [7*N-1:0] ys;
    logic [3*N-1:0] cs;
    int             writes;
    int             cycles;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(input logic [N-1:0] act, input int x0, input int y0,
                              input int c0, input int x2, input int y2, input int c2,
                              input int w, input int cyc);
    vec_t v;
    v.act    = act;
    v.xs     = (8*N)'(x0) | ((8*N)'(x2) << 16);
    v.ys     = (7*N)'(y0) | ((7*N)'(y2) << 14);
    v.cs     = (3*N)'(c0) | ((3*N)'(c2) << 6);
    v.writes = w;
    v.cycles = cyc;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    int w, cyc, fw, da, exp_cyc;
    logic [N-1:0] ra;
    logic [8*N-1:0] rx;
    logic [7*N-1:0] ry;
    logic [3*N-1:0] rc;

    // first frame draws; then move, add slot 2, kill it, clip at edges
    vt[0] = mk(6'b000001,  10,  20, 4,  0, 0, 0, 16, 29);
    vt[1] = mk(6'b000001,  11,  20, 4,  0, 0, 0, 32, 45);
    vt[2] = mk(6'b000101,  11,  20, 4, 50, 5, 2, 48, 61);
    vt[3] = mk(6'b000001,  11,  20, 4,  0, 0, 0, 48, 61);
    vt[4] = mk(6'b000001, 158,  20, 4,  0, 0, 0, 24, 45);
    vt[5] = mk(6'b000001, 254,  20, 4,  0, 0, 0,  8, 45);
    vt[6] = mk(6'b000001,  30, 118, 4,  0, 0, 0,  8, 45);
    vt[7] = mk(6'b000000,   0,   0, 0,  0, 0, 0,  8, 29);
    vt[8] = mk(6'b000000,   0,   0, 0,  0, 0, 0,  0, 13);

    model_reset();

    // reset held with frame_tick toggling: everything stays quiet
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      frame_tick = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_outputs", {busy, frame_done, overrun, state_dbg, 11'(obs())}, 0);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", {busy, overrun, state_dbg, 21'(obs())}, 0);

    // table-driven frames
    for (int v = 0; v < 9; v++) begin
      run_frame($sformatf("vec%0d", v), vt[v].act, vt[v].xs, vt[v].ys, vt[v].cs, -1,
                w, cyc, fw, da);
      check($sformatf("vec%0d_writes", v), w, vt[v].writes);
      check($sformatf("vec%0d_cycles", v), cyc, vt[v].cycles);
      if (v == 0) check("vec0_first_write", fw, 7);
    end
    check("overrun_clear", 32'(overrun), 0);

    // frame_tick during D_PIX: flagged, frame untouched
    run_frame("ovr", 6'b000001, 48'd40, 42'd40, 18'd5, 10, w, cyc, fw, da);
    check("ovr_writes", w, 16);
    check("ovr_cycles", cyc, 29);
    check("ovr_flag", 32'(overrun), 1);
    @(posedge clk);
    #1;
    check("ovr_sticky", 32'(overrun), 1);

    // reset in the middle of erasing slot 0
    start_frame(6'b000010, 48'd60 << 8, 42'd60 << 7, 18'd3 << 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_state_epix", 32'(state_dbg), 32'(E_PIX));
    check("mid_we", 32'(pif.writeEn), 1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_out", {busy, overrun, state_dbg, 21'(obs())}, 0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    run_frame("after_rst", 6'b000010, 48'd60 << 8, 42'd60 << 7, 18'd3 << 3, -1,
              w, cyc, fw, da);
    check("after_rst_writes", w, 16);
    check("after_rst_cycles", cyc, 29);

    // randomized frames; length from the popcount rule
    for (int r = 0; r < 25; r++) begin
      ra = N'($urandom);
      for (int i = 0; i < N; i++) begin
        rx[8*i +: 8] = 8'($urandom_range(0, 255));
        ry[7*i +: 7] = 7'($urandom_range(0, 127));
        rc[3*i +: 3] = 3'($urandom_range(0, 7));
      end
      exp_cyc = 2*N + 16*($countones(m_cur_act) + $countones(ra)) + 1;
      run_frame($sformatf("rnd%0d", r), ra, rx, ry, rc, -1, w, cyc, fw, da);
      check($sformatf("rnd%0d_cycles", r), cyc, exp_cyc);
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_frame_scheduler.md
# sprite_frame_scheduler

Per-frame sequencer that owns the single VGA pixel-write port and shares it among N sprite sources (aliens, ship, beam). On each frame tick it snapshots every sprite's position, colour and active flag. It then erases the previous frame's footprints with black and draws the new ones, emitting one pixel per cycle. It replaces the hand-chained per-sprite draw FSM between the game objects and the VGA adapter.

## Interface
Parameters:
- N_SPR, 6, number of sprite slots; slot 0 is drawn first.
- SPR_W, 4, sprite width in pixels.
- SPR_H, 4, sprite height in pixels.
- X_MAX, 160, screen width; pixels with x >= X_MAX are not written.
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are not written.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse that starts a frame.
- active  in  N_SPR  per-slot enable.
- spr_x  in  8*N_SPR  slot i occupies bits [8i+7:8i]; top-left x.
- spr_y  in  7*N_SPR  slot i occupies bits [7i+6:7i]; top-left y.
- spr_c  in  3*N_SPR  slot i occupies bits [3i+2:3i]; colour.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- writeEn  out  1  pixel-write strobe.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- overrun  out  1  sticky; cleared only by reset.

## Operation
- States and transitions:
  - IDLE: on frame_tick, go to E_SEL.
  - E_SEL: if slot is active in prev, go to E_PIX; else go to the next slot.
  - E_PIX: erase one pixel per cycle.
  - D_SEL: if slot is active in cur, go to D_PIX; else go to the next slot.
  - D_PIX: draw one pixel per cycle.
  - DONE: assert frame_done, then go to IDLE.
- Leaving E_SEL/E_PIX after slot N_SPR-1 goes to D_SEL with slot 0. Leaving D_SEL/D_PIX after slot N_SPR-1 goes to DONE.
- Snapshot, on the frame_tick edge in IDLE:
  - prev <= cur.
  - cur <= {active, spr_x, spr_y, spr_c}.
  - Slot index and pixel counters cleared.
- Inputs may change freely while busy; only the snapshots are used.
- Erase:
  - Uses prev coordinates with colour 3'b000.
  - A slot that has since gone inactive (killed, beam spent) is still erased.
- Draw: uses cur coordinates and cur colour.
- Pixel order within a sprite:
  - Row-major: dx 0..SPR_W-1 inner, dy 0..SPR_H-1 outer.
  - The sprite is finished on the pixel where dx==SPR_W-1 and dy==SPR_H-1.
  - The next state is then the SEL state for idx+1, or the phase change.
- Address arithmetic:
  - px = {1'b0,base_x} + dx, 9 bits; py = {1'b0,base_y} + dy, 8 bits. No wrap-around.
  - On out-of-range pixels (px >= X_MAX or py >= Y_MAX) writeEn=0, but the cycle is still consumed.
- Outputs:
  - x/y carry the low 8/7 bits of px/py.
  - writeEn=1 only in E_PIX/D_PIX with an in-range pixel.
  - In all other states x, y and colour hold 0.
- frame_tick outside IDLE (including DONE) is ignored and sets overrun; the frame in progress is unaffected.
- Frame length in cycles = 2*N_SPR + SPR_W*SPR_H*(popcount(prev.active) + popcount(cur.active)) + 1.

## Timing
- Outputs are Moore decodes of registered state and counters.
- frame_tick sampled at edge t puts E_SEL slot 0 in cycle t+1.
- Each SEL state lasts 1 cycle. Each sprite occupies 1 SEL cycle + SPR_W*SPR_H PIX cycles.
- frame_done is high exactly during the DONE cycle; busy drops the following cycle.
- Reset values:
  - State IDLE.
  - x, y, colour, writeEn, busy, frame_done, overrun = 0.
  - prev.active and cur.active = 0, so the first frame erases nothing.
- Reset mid-frame:
  - Abort immediately; writeEn=0 from the next cycle.
  - Snapshots are cleared, so no stale erase occurs after reset.

## Structure
- Shared package `game_pkg`:
  - State encoding localparams (IDLE, E_SEL, E_PIX, D_SEL, D_PIX, DONE).
  - SCREEN_W=160, SCREEN_H=120, SPR_W=4, SPR_H=4.
  - Colour constant BLACK=3'b000.
- Sub-module `sprite_pixel_counter`:
  - Function: dx/dy counters with clear, enable and last outputs.
  - Must be reusable by `beam_coord` and `square_coord` replacements.
- Top: FSM, slot index, snapshot registers, width-extended address adders, range check.

## Test plan
- Reset: hold resetn=0 with frame_tick pulsing -> all outputs 0, busy=0, overrun=0 throughout.
- Single sprite draw: slot 0 active at (10,20), c=4, others inactive; tick -> 16 writes (10,20),(11,20)…(13,23), colour 4, in cycles t+8..t+23; frame_done at t+29; 29 busy cycles total.
- Move and erase: next tick with slot 0 at (11,20) -> 16 writes at (10..13,20..23) colour 0, then 16 at (11..14,20..23) colour 4; 45 busy cycles.
- Kill: slot 2 active last frame at (50,5), now inactive -> its footprint erased with 0, no draw for slot 2.
- Screen edge: x=158 -> only columns 158,159 written (8 writes); x=254 -> 0 writes, still 16 PIX cycles; y=118 -> rows 118,119 only.
- Overrun and reset mid-frame: tick during D_PIX -> overrun=1, frame completes with unchanged write sequence; resetn=0 mid-E_PIX -> writeEn=0 next cycle, state IDLE, next frame erases nothing.
